// File: rtl/wall_sequencer.sv
// wall_sequencer
//
// Plays the walls of one game run. Starting at wall index 0 it reads each
// mask from the wall bitmask ROM and holds it as the active wall while the
// wall approaches over APPROACH_FRAMES video frames. When the wall arrives it
// pulses check_out, waits GAP_FRAMES frames, and moves on to the next index.
// After the last wall's gap it raises done_out until the next start.
//
// Ports
//   clk_in           system clock, single domain
//   rst_in           synchronous, active-high reset
//   start_in         start a run (honoured only in IDLE and DONE)
//   frame_in         one-cycle pulse per video frame
//   bitmask_idx_out  ROM address of the wall being fetched or played
//   mask_req_out     one-cycle ROM read request
//   mask_valid_in    ROM response valid (fixed 2-cycle latency)
//   mask_data_in     ROM response data, qualified by mask_valid_in
//   wall_mask_out    latched mask of the current wall
//   wall_active_out  high while a wall is approaching
//   depth_out        frames left until the collision check
//   check_out        one-cycle strobe when the wall arrives
//   done_out         level, high once the last wall's gap has finished
//   state_out        current FSM state (debug visibility)
//
// Handshake: mask_req_out is a single-cycle pulse with no back-pressure; the
// ROM answers with exactly one mask_valid_in cycle two cycles later. A
// response is accepted only while waiting for it (WAIT). If none arrives
// before the timeout the same index is requested again.
//
// Parameter constraints: NUM_WALLS >= 2, APPROACH_FRAMES >= 1,
// GAP_FRAMES >= 1, FETCH_TIMEOUT >= 2.

module wall_sequencer #(
  parameter int NUM_WALLS       = 10,
  parameter int BIT_MASK_SIZE   = 3600,
  parameter int APPROACH_FRAMES = 180,
  parameter int GAP_FRAMES      = 30,
  parameter int FETCH_TIMEOUT   = 8
) (
  input  logic                                  clk_in,
  input  logic                                  rst_in,
  input  logic                                  start_in,
  input  logic                                  frame_in,
  output logic [$clog2(NUM_WALLS)-1:0]          bitmask_idx_out,
  output logic                                  mask_req_out,
  input  logic                                  mask_valid_in,
  input  logic [BIT_MASK_SIZE-1:0]              mask_data_in,
  output logic [BIT_MASK_SIZE-1:0]              wall_mask_out,
  output logic                                  wall_active_out,
  output logic [$clog2(APPROACH_FRAMES+1)-1:0]  depth_out,
  output logic                                  check_out,
  output logic                                  done_out,
  output logic [2:0]                            state_out
);

  localparam int IDX_W   = $clog2(NUM_WALLS);
  localparam int DEPTH_W = $clog2(APPROACH_FRAMES + 1);
  localparam int GAP_W   = $clog2(GAP_FRAMES + 1);
  localparam int TO_W    = $clog2(FETCH_TIMEOUT + 1);

  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_WALLS - 1);
  localparam logic [IDX_W-1:0]   IDX_ONE    = IDX_W'(1);
  localparam logic [DEPTH_W-1:0] DEPTH_INIT = DEPTH_W'(APPROACH_FRAMES);
  localparam logic [DEPTH_W-1:0] DEPTH_ONE  = DEPTH_W'(1);
  localparam logic [GAP_W-1:0]   GAP_INIT   = GAP_W'(GAP_FRAMES);
  localparam logic [GAP_W-1:0]   GAP_ONE    = GAP_W'(1);
  localparam logic [TO_W-1:0]    TO_ONE     = TO_W'(1);
  // The counter is compared before it increments, so the value one below
  // the final count marks the cycle in which it reaches FETCH_TIMEOUT-1.
  localparam logic [TO_W-1:0]    TO_LAST    = TO_W'(FETCH_TIMEOUT - 2);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_WAIT     = 3'd2,
    S_APPROACH = 3'd3,
    S_GAP      = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  state_t state;
  state_t next_state;

  logic [GAP_W-1:0] gap_cnt;
  logic [TO_W-1:0]  wait_cnt;

  // Next values of every registered output and counter
  logic [IDX_W-1:0]         idx_d;
  logic                     req_d;
  logic [BIT_MASK_SIZE-1:0] mask_d;
  logic                     active_d;
  logic [DEPTH_W-1:0]       depth_d;
  logic                     check_d;
  logic                     done_d;
  logic [GAP_W-1:0]         gap_d;
  logic [TO_W-1:0]          wait_d;

  logic last_wall;
  logic wait_expire;
  logic arrive;
  logic gap_end;

  assign last_wall   = (bitmask_idx_out == IDX_LAST);
  assign wait_expire = (wait_cnt == TO_LAST);
  assign arrive      = frame_in && (depth_out == DEPTH_ONE);
  assign gap_end     = frame_in && (gap_cnt == GAP_ONE);
  assign state_out   = state;

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (start_in) next_state = S_FETCH;
      end
      S_FETCH: begin
        next_state = S_WAIT;
      end
      S_WAIT: begin
        // A response wins over a timeout landing in the same cycle.
        if (mask_valid_in)    next_state = S_APPROACH;
        else if (wait_expire) next_state = S_FETCH;
      end
      S_APPROACH: begin
        if (arrive) next_state = S_GAP;
      end
      S_GAP: begin
        if (gap_end) next_state = last_wall ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        if (start_in) next_state = S_FETCH;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Output logic: next values for the registered outputs and counters.
  // Everything holds by default; each state only touches what it owns.
  // ---------------------------------------------------------------------
  always_comb begin
    idx_d    = bitmask_idx_out;
    req_d    = 1'b0;
    mask_d   = wall_mask_out;
    active_d = wall_active_out;
    depth_d  = depth_out;
    check_d  = 1'b0;
    done_d   = done_out;
    gap_d    = gap_cnt;
    wait_d   = wait_cnt;
    case (state)
      S_IDLE: begin
        if (start_in) idx_d = '0;
      end
      S_FETCH: begin
        // The request register is loaded here, so the ROM sees the pulse in
        // the cycle after FETCH, which is the first WAIT cycle.
        req_d  = 1'b1;
        wait_d = '0;
      end
      S_WAIT: begin
        wait_d = wait_cnt + TO_ONE;
        if (mask_valid_in) begin
          mask_d   = mask_data_in;
          depth_d  = DEPTH_INIT;
          active_d = 1'b1;
        end
      end
      S_APPROACH: begin
        if (frame_in && (depth_out != '0)) begin
          depth_d = depth_out - DEPTH_ONE;
          if (depth_out == DEPTH_ONE) begin
            check_d  = 1'b1;
            active_d = 1'b0;
            gap_d    = GAP_INIT;
          end
        end
      end
      S_GAP: begin
        if (frame_in && (gap_cnt != '0)) begin
          gap_d = gap_cnt - GAP_ONE;
          if (gap_cnt == GAP_ONE) begin
            if (last_wall) done_d = 1'b1;
            else           idx_d  = bitmask_idx_out + IDX_ONE;
          end
        end
      end
      S_DONE: begin
        done_d = 1'b1;
        if (start_in) begin
          done_d = 1'b0;
          idx_d  = '0;
        end
      end
      default: begin
        done_d = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Output and counter registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      bitmask_idx_out <= '0;
      mask_req_out    <= 1'b0;
      wall_mask_out   <= '0;
      wall_active_out <= 1'b0;
      depth_out       <= '0;
      check_out       <= 1'b0;
      done_out        <= 1'b0;
      gap_cnt         <= '0;
      wait_cnt        <= '0;
    end else begin
      bitmask_idx_out <= idx_d;
      mask_req_out    <= req_d;
      wall_mask_out   <= mask_d;
      wall_active_out <= active_d;
      depth_out       <= depth_d;
      check_out       <= check_d;
      done_out        <= done_d;
      gap_cnt         <= gap_d;
      wait_cnt        <= wait_d;
    end
  end

endmodule

// File: tb/tb_wall_sequencer.sv
// Directed testbench for wall_sequencer with a small configuration
// (3 walls, 4 approach frames, 2 gap frames, timeout 8) and a 2-cycle ROM
// model returning idx + 0xA5.

module tb_wall_sequencer;

  localparam int NW  = 3;
  localparam int MW  = 16;
  localparam int AF  = 4;
  localparam int GF  = 2;
  localparam int FTO = 8;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_FETCH    = 3'd1;
  localparam logic [2:0] ST_WAIT     = 3'd2;
  localparam logic [2:0] ST_APPROACH = 3'd3;
  localparam logic [2:0] ST_GAP      = 3'd4;
  localparam logic [2:0] ST_DONE     = 3'd5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_in;
  logic          start_in;
  logic          frame_in;
  logic [1:0]    bitmask_idx_out;
  logic          mask_req_out;
  logic          mask_valid_in;
  logic [MW-1:0] mask_data_in;
  logic [MW-1:0] wall_mask_out;
  logic          wall_active_out;
  logic [2:0]    depth_out;
  logic          check_out;
  logic          done_out;
  logic [2:0]    state_out;

  wall_sequencer #(
    .NUM_WALLS(NW), .BIT_MASK_SIZE(MW), .APPROACH_FRAMES(AF),
    .GAP_FRAMES(GF), .FETCH_TIMEOUT(FTO)
  ) dut (
    .clk_in(clk), .rst_in(rst_in), .start_in(start_in), .frame_in(frame_in),
    .bitmask_idx_out(bitmask_idx_out), .mask_req_out(mask_req_out),
    .mask_valid_in(mask_valid_in), .mask_data_in(mask_data_in),
    .wall_mask_out(wall_mask_out), .wall_active_out(wall_active_out),
    .depth_out(depth_out), .check_out(check_out), .done_out(done_out),
    .state_out(state_out)
  );

  // ---------------- ROM model ----------------
  int            req_count   = 0;
  int            drop_req_no = -1;
  logic          pend        = 1'b0;
  logic          pend_drop   = 1'b0;
  logic [1:0]    pend_idx    = '0;
  logic          rom_valid   = 1'b0;
  logic [MW-1:0] rom_data    = '0;
  logic          extra_valid;
  logic [MW-1:0] extra_data;

  always @(posedge clk) begin
    if (mask_req_out) begin
      pend      <= 1'b1;
      pend_idx  <= bitmask_idx_out;
      pend_drop <= (req_count == drop_req_no);
      req_count <= req_count + 1;
    end else begin
      pend <= 1'b0;
    end
    rom_valid <= pend && !pend_drop;
    rom_data  <= MW'(pend_idx) + MW'(16'hA5);
  end

  assign mask_valid_in = rom_valid | extra_valid;
  assign mask_data_in  = extra_valid ? extra_data : rom_data;

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  int check_pulses = 0;
  int req_pulses   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Every request must carry the next expected wall index.
  always @(negedge clk) begin
    if (check_out) check_pulses++;
    if (mask_req_out) begin
      req_pulses++;
      if (exp_q.size() == 0) check("req_unexpected", 32'd1, 32'd0);
      else                   check("req_idx", 32'(bitmask_idx_out), exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pulse();
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
  endtask

  task automatic frame_pulse();
    frame_in = 1'b1;
    tick();
    frame_in = 1'b0;
  endtask

  task automatic wait_active(input string tag);
    int n;
    n = 0;
    while (!wall_active_out && n < 30) begin
      tick();
      n++;
    end
    check(tag, 32'(wall_active_out), 32'd1);
  endtask

  task automatic wait_req(input string tag);
    int n;
    n = 0;
    while (!mask_req_out && n < 30) begin
      tick();
      n++;
    end
    check(tag, 32'(mask_req_out), 32'd1);
  endtask

  // Plays one wall from its fetch to the end of its gap.
  task automatic run_wall(input int idx);
    wait_active("wall_active_rise");
    check("wall_mask", 32'(wall_mask_out), 32'(idx + 'hA5));
    check("depth_init", 32'(depth_out), 32'd4);
    for (int f = 0; f < AF; f++) begin
      frame_pulse();
      check("depth_step", 32'(depth_out), 32'(3 - f));
      check("check_timing", 32'(check_out), (f == AF - 1) ? 32'd1 : 32'd0);
    end
    check("active_fall", 32'(wall_active_out), 32'd0);
    check("done_low_mid_run", 32'(done_out), 32'd0);
    frame_pulse();
    frame_pulse();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int req_before;
    rst_in = 1'b1; start_in = 1'b0; frame_in = 1'b0;
    extra_valid = 1'b0; extra_data = '0;
    repeat (3) tick();
    rst_in = 1'b0;
    tick();

    // Reset state
    check("rst_state", 32'(state_out), 32'(ST_IDLE));
    check("rst_idx", 32'(bitmask_idx_out), 32'd0);
    check("rst_req", 32'(mask_req_out), 32'd0);
    check("rst_mask", 32'(wall_mask_out), 32'd0);
    check("rst_active", 32'(wall_active_out), 32'd0);
    check("rst_depth", 32'(depth_out), 32'd0);
    check("rst_check", 32'(check_out), 32'd0);
    check("rst_done", 32'(done_out), 32'd0);

    // Start latency, wall 0
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
    start_pulse();
    check("s_fetch_state", 32'(state_out), 32'(ST_FETCH));
    check("s_req_n0", 32'(mask_req_out), 32'd0);
    tick();
    check("s_req_n1", 32'(mask_req_out), 32'd1);
    check("s_idx_n1", 32'(bitmask_idx_out), 32'd0);
    tick();
    check("s_req_n2", 32'(mask_req_out), 32'd0);
    tick();
    check("s_active_n3", 32'(wall_active_out), 32'd0);
    tick();
    check("s_mask_n4", 32'(wall_mask_out), 32'hA5);
    check("s_depth_n4", 32'(depth_out), 32'd4);
    check("s_active_n4", 32'(wall_active_out), 32'd1);

    // Approach of wall 0
    for (int f = 0; f < AF; f++) begin
      frame_pulse();
      check("a_depth", 32'(depth_out), 32'(3 - f));
      check("a_check", 32'(check_out), (f == AF - 1) ? 32'd1 : 32'd0);
      check("a_active", 32'(wall_active_out), (f == AF - 1) ? 32'd0 : 32'd1);
    end
    tick();
    check("a_check_single", 32'(check_out), 32'd0);
    check("a_mask_hold", 32'(wall_mask_out), 32'hA5);
    frame_pulse();
    check("g_state_mid", 32'(state_out), 32'(ST_GAP));
    frame_pulse();
    check("g_state_fetch", 32'(state_out), 32'(ST_FETCH));
    check("g_idx1", 32'(bitmask_idx_out), 32'd1);
    tick();
    check("g_req_idx1", 32'(mask_req_out), 32'd1);

    // Remaining walls of the run
    run_wall(1);
    run_wall(2);
    check("run_done", 32'(done_out), 32'd1);
    check("run_state_done", 32'(state_out), 32'(ST_DONE));
    check("run_check_pulses", 32'(check_pulses), 32'd3);
    check("run_req_pulses", 32'(req_pulses), 32'd3);
    frame_pulse();
    check("done_holds", 32'(done_out), 32'd1);

    // Restart from DONE, then reset in APPROACH at depth 2
    exp_q.push_back(0);
    start_pulse();
    check("re_done_clear", 32'(done_out), 32'd0);
    check("re_idx0", 32'(bitmask_idx_out), 32'd0);
    wait_active("re_active");
    check("re_mask", 32'(wall_mask_out), 32'hA5);
    frame_pulse();
    frame_pulse();
    check("re_depth2", 32'(depth_out), 32'd2);
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    check("mr_state", 32'(state_out), 32'(ST_IDLE));
    check("mr_mask", 32'(wall_mask_out), 32'd0);
    check("mr_active", 32'(wall_active_out), 32'd0);
    check("mr_depth", 32'(depth_out), 32'd0);
    check("mr_idx", 32'(bitmask_idx_out), 32'd0);
    check("mr_req", 32'(mask_req_out), 32'd0);
    extra_valid = 1'b1; extra_data = 16'h5A5A;
    tick();
    extra_valid = 1'b0;
    check("late_mask", 32'(wall_mask_out), 32'd0);
    check("late_active", 32'(wall_active_out), 32'd0);
    check("late_state", 32'(state_out), 32'(ST_IDLE));

    // Dropped ROM response, request reissued after the timeout
    drop_req_no = req_count;
    exp_q.push_back(0); exp_q.push_back(0);
    start_pulse();
    wait_req("drop_first_req");
    n = 0;
    tick();
    n++;
    while (!mask_req_out && n < 30) begin
      tick();
      n++;
    end
    check("drop_reissue_gap", 32'(n), 32'd8);
    check("drop_idx_same", 32'(bitmask_idx_out), 32'd0);
    wait_active("drop_active");
    check("drop_mask", 32'(wall_mask_out), 32'hA5);
    for (int f = 0; f < AF + GF; f++) frame_pulse();

    // start_in and frame_in held high through WAIT and APPROACH of wall 1
    exp_q.push_back(1);
    req_before = req_pulses;
    wait_req("hold_req");
    start_in = 1'b1; frame_in = 1'b1;
    tick();
    check("hold_depth_wait", 32'(depth_out), 32'd0);
    check("hold_active_wait", 32'(wall_active_out), 32'd0);
    wait_active("hold_active");
    check("hold_depth_latch", 32'(depth_out), 32'd4);
    check("hold_mask", 32'(wall_mask_out), 32'hA6);
    for (int f = 0; f < AF; f++) begin
      tick();
      check("hold_depth", 32'(depth_out), 32'(3 - f));
    end
    start_in = 1'b0; frame_in = 1'b0;
    check("hold_check", 32'(check_out), 32'd1);
    check("hold_state_gap", 32'(state_out), 32'(ST_GAP));
    check("hold_idx", 32'(bitmask_idx_out), 32'd1);
    check("hold_no_extra_req", 32'(req_pulses - req_before), 32'd1);
    exp_q.push_back(2);
    frame_pulse();
    frame_pulse();
    check("hold_next_idx", 32'(bitmask_idx_out), 32'd2);
    repeat (3) tick();

    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
